// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the word-to-byte memory sequencer.
package cpu_bus_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    RESP
  } state_t;

endpackage

// File: rtl/byte_lane_select.sv
// Picks logical byte `lane` out of a word, honouring the configured endianness.
module byte_lane_select
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BIG_ENDIAN = 0
) (
  input  logic [DATA_W-1:0] word,
  input  logic [3:0]        lane,
  output logic [BYTE_W-1:0] byte_sel
);

  localparam int unsigned N = DATA_W / BYTE_W;

  // Scan physical byte slots and return the one that holds logical byte `lane`.
  always_comb begin
    byte_sel = '0;
    for (int unsigned p = 0; p < N; p++) begin
      if (lane == 4'((BIG_ENDIAN != 0) ? (N - 1 - p) : p)) begin
        byte_sel = word[BYTE_W*p +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/word_memory_sequencer.sv
// Splits word read/write requests into byte strobes on an 8-bit memory port.
module word_memory_sequencer
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned BIG_ENDIAN = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [ADDR_W-1:0] Req_Address,
  input  logic [DATA_W-1:0] Req_WData,
  output logic              Rsp_Valid,
  output logic [DATA_W-1:0] Rsp_RData,
  output logic              Mem_CS,
  output logic              Mem_WR,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [7:0]        Mem_Data,
  input  logic [7:0]        Mem_Out
);

  localparam int unsigned N      = DATA_W / BYTE_W;
  localparam logic [3:0]  LAST_K = 4'(N - 1);

  state_t              state;
  logic [3:0]          k;
  logic [3:0]          next_k;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   sel_word;
  logic [3:0]          sel_lane;
  logic [BYTE_W-1:0]   wr_byte;
  logic                cap_pending;
  logic [3:0]          cap_k;
  logic [DATA_W-1:0]   slot_index;
  logic [BYTE_W-1:0]   cap_slot;

  assign next_k = k + 4'd1;

  // Byte to drive next: byte 0 of the incoming word on accept, else byte k+1 of the latched word.
  always_comb begin
    sel_word = (state == IDLE) ? Req_WData : wdata_q;
    sel_lane = (state == IDLE) ? 4'd0 : next_k;
  end

  byte_lane_select #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) write_lane (
    .word     (sel_word),
    .lane     (sel_lane),
    .byte_sel (wr_byte)
  );

  // Word whose byte p holds the value p: selecting lane k from it yields the
  // physical slot that logical byte k occupies, so the same selector targets read lanes.
  always_comb begin
    slot_index = '0;
    for (int unsigned p = 0; p < N; p++) begin
      slot_index[BYTE_W*p +: BYTE_W] = 8'(p);
    end
  end

  byte_lane_select #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) read_lane (
    .word     (slot_index),
    .lane     (cap_k),
    .byte_sel (cap_slot)
  );

  // Sequencer FSM with registered handshake and memory-port outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      k           <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      Req_Ready   <= 1'b1;
      Rsp_Valid   <= 1'b0;
      Mem_CS      <= 1'b0;
      Mem_WR      <= 1'b0;
      Mem_Address <= '0;
      Mem_Data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Req_Valid && Req_Ready) begin
            state       <= XFER;
            k           <= '0;
            write_q     <= Req_Write;
            addr_q      <= Req_Address;
            wdata_q     <= Req_WData;
            Req_Ready   <= 1'b0;
            Mem_CS      <= 1'b1;
            Mem_WR      <= Req_Write;
            Mem_Address <= Req_Address;
            Mem_Data    <= Req_Write ? wr_byte : '0;
          end
        end
        XFER: begin
          if (k == LAST_K) begin
            k           <= '0;
            Mem_CS      <= 1'b0;
            Mem_WR      <= 1'b0;
            Mem_Address <= '0;
            Mem_Data    <= '0;
            if (write_q) begin
              state     <= RESP;
              Rsp_Valid <= 1'b1;
            end else begin
              state     <= DRAIN;
            end
          end else begin
            k           <= next_k;
            Mem_Address <= addr_q + ADDR_W'(next_k);
            Mem_Data    <= write_q ? wr_byte : '0;
          end
        end
        DRAIN: begin
          state     <= RESP;
          Rsp_Valid <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          Rsp_Valid <= 1'b0;
          Req_Ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture each read byte one cycle after its strobe into its endian-mapped lane.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cap_pending <= 1'b0;
      cap_k       <= '0;
      Rsp_RData   <= '0;
    end else begin
      cap_pending <= (state == XFER) && !write_q;
      cap_k       <= k;
      if (cap_pending) begin
        for (int unsigned p = 0; p < N; p++) begin
          if (cap_slot == 8'(p)) begin
            Rsp_RData[BYTE_W*p +: BYTE_W] <= Mem_Out;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_word_memory_sequencer.sv
// Scoreboard bench for word_memory_sequencer: three configurations share one byte memory model.
module tb_word_memory_sequencer;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        wr;
  } strobe_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_address;
  logic [31:0] req_wdata;
  logic [7:0]  mem_out;
  logic [1:0]  sel;

  logic        a_ready, a_rsp_valid, a_cs, a_wr;
  logic [15:0] a_rdata, a_addr;
  logic [7:0]  a_data;
  logic        b_ready, b_rsp_valid, b_cs, b_wr;
  logic [31:0] b_rdata;
  logic [15:0] b_addr;
  logic [7:0]  b_data;
  logic        c_ready, c_rsp_valid, c_cs, c_wr;
  logic [7:0]  c_rdata;
  logic [15:0] c_addr;
  logic [7:0]  c_data;

  logic        obs_ready, obs_rsp, obs_cs, obs_wr;
  logic [31:0] obs_rdata;
  logic [15:0] obs_addr;
  logic [7:0]  obs_data;

  logic [7:0]  mem [0:65535];
  strobe_t     sq[$];
  logic [31:0] rq[$];
  logic [31:0] last_rdata [3];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  word_memory_sequencer #(.DATA_W(16), .ADDR_W(16), .BIG_ENDIAN(0)) dut_a (
    .Clock(clk), .Reset(rst), .Req_Valid(req_valid && (sel == 2'd0)), .Req_Ready(a_ready),
    .Req_Write(req_write), .Req_Address(req_address), .Req_WData(req_wdata[15:0]),
    .Rsp_Valid(a_rsp_valid), .Rsp_RData(a_rdata), .Mem_CS(a_cs), .Mem_WR(a_wr),
    .Mem_Address(a_addr), .Mem_Data(a_data), .Mem_Out(mem_out));

  word_memory_sequencer #(.DATA_W(32), .ADDR_W(16), .BIG_ENDIAN(1)) dut_b (
    .Clock(clk), .Reset(rst), .Req_Valid(req_valid && (sel == 2'd1)), .Req_Ready(b_ready),
    .Req_Write(req_write), .Req_Address(req_address), .Req_WData(req_wdata),
    .Rsp_Valid(b_rsp_valid), .Rsp_RData(b_rdata), .Mem_CS(b_cs), .Mem_WR(b_wr),
    .Mem_Address(b_addr), .Mem_Data(b_data), .Mem_Out(mem_out));

  word_memory_sequencer #(.DATA_W(8), .ADDR_W(16), .BIG_ENDIAN(0)) dut_c (
    .Clock(clk), .Reset(rst), .Req_Valid(req_valid && (sel == 2'd2)), .Req_Ready(c_ready),
    .Req_Write(req_write), .Req_Address(req_address), .Req_WData(req_wdata[7:0]),
    .Rsp_Valid(c_rsp_valid), .Rsp_RData(c_rdata), .Mem_CS(c_cs), .Mem_WR(c_wr),
    .Mem_Address(c_addr), .Mem_Data(c_data), .Mem_Out(mem_out));

  always_comb begin
    case (sel)
      2'd1: begin
        obs_ready = b_ready; obs_rsp = b_rsp_valid; obs_rdata = b_rdata;
        obs_cs = b_cs; obs_wr = b_wr; obs_addr = b_addr; obs_data = b_data;
      end
      2'd2: begin
        obs_ready = c_ready; obs_rsp = c_rsp_valid; obs_rdata = {24'd0, c_rdata};
        obs_cs = c_cs; obs_wr = c_wr; obs_addr = c_addr; obs_data = c_data;
      end
      default: begin
        obs_ready = a_ready; obs_rsp = a_rsp_valid; obs_rdata = {16'd0, a_rdata};
        obs_cs = a_cs; obs_wr = a_wr; obs_addr = a_addr; obs_data = a_data;
      end
    endcase
  end

  // Byte-wide synchronous memory: write on strobe, read data valid the next cycle.
  always @(posedge clk) begin
    if (obs_cs) begin
      if (obs_wr) mem[obs_addr] <= obs_data;
      else        mem_out <= mem[obs_addr];
    end
  end

  function automatic int unsigned nbytes();
    return (sel == 2'd1) ? 4 : (sel == 2'd2) ? 1 : 2;
  endfunction

  function automatic logic [7:0] lane_of(input logic [31:0] w, input int unsigned k);
    int unsigned n   = nbytes();
    int unsigned pos = (sel == 2'd1) ? (n - 1 - k) : k;
    return 8'(w >> (8 * pos));
  endfunction

  task automatic push_req(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp);
    strobe_t s;
    for (int unsigned k = 0; k < nbytes(); k++) begin
      s.addr = addr + 16'(k);
      s.data = wr ? lane_of(wdata, k) : 8'd0;
      s.wr   = wr;
      sq.push_back(s);
    end
    if (wr) rq.push_back(last_rdata[sel]);
    else begin
      rq.push_back(exp);
      last_rdata[sel] = exp;
    end
  endtask

  task automatic observe_cycle(input string name, input bit exp_ready, input bit exp_cs,
                               input bit exp_rsp);
    strobe_t     s;
    logic [31:0] r;
    tests++;
    if (obs_ready !== exp_ready) begin
      fails++; $display("FAIL %s ready: got %0b expected %0b", name, obs_ready, exp_ready);
    end
    tests++;
    if (obs_cs !== exp_cs) begin
      fails++; $display("FAIL %s mem_cs: got %0b expected %0b", name, obs_cs, exp_cs);
    end
    if (obs_cs === 1'b1) begin
      tests++;
      if (sq.size() == 0) begin
        fails++; $display("FAIL %s strobe: got unexpected addr %h data %h", name, obs_addr, obs_data);
      end else begin
        s = sq.pop_front();
        if ({obs_addr, obs_data, obs_wr} !== {s.addr, s.data, s.wr}) begin
          fails++;
          $display("FAIL %s strobe: got addr %h data %h wr %0b expected addr %h data %h wr %0b",
                   name, obs_addr, obs_data, obs_wr, s.addr, s.data, s.wr);
        end
      end
    end else begin
      tests++;
      if ({obs_wr, obs_addr, obs_data} !== 25'd0) begin
        fails++;
        $display("FAIL %s idle bus: got wr %0b addr %h data %h expected zeros", name, obs_wr, obs_addr, obs_data);
      end
    end
    tests++;
    if (obs_rsp !== exp_rsp) begin
      fails++; $display("FAIL %s rsp_valid: got %0b expected %0b", name, obs_rsp, exp_rsp);
    end
    if (obs_rsp === 1'b1) begin
      tests++;
      if (rq.size() == 0) begin
        fails++; $display("FAIL %s rsp: got unexpected response %h", name, obs_rdata);
      end else begin
        r = rq.pop_front();
        if (obs_rdata !== r) begin
          fails++; $display("FAIL %s rdata: got %h expected %h", name, obs_rdata, r);
        end
      end
    end
  endtask

  task automatic drain_check(input string name);
    tests++;
    if (sq.size() != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL %s leftovers: got %0d strobes %0d responses outstanding expected 0 0", name, sq.size(), rq.size());
    end
    sq.delete();
    rq.delete();
  endtask

  task automatic do_req(input string name, input bit wr, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp);
    int unsigned n = nbytes();
    int unsigned lat = wr ? n + 1 : n + 2;
    @(negedge clk);
    tests++;
    if (obs_ready !== 1'b1) begin
      fails++; $display("FAIL %s pre-ready: got %0b expected 1", name, obs_ready);
    end
    req_valid = 1'b1; req_write = wr; req_address = addr; req_wdata = wdata;
    push_req(wr, addr, wdata, exp);
    @(posedge clk);
    for (int unsigned c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0; req_write = ~wr;
        req_address = 16'($urandom); req_wdata = $urandom;
      end
      observe_cycle(name, 1'b0, c <= n, c == lat);
    end
    @(negedge clk);
    observe_cycle(name, 1'b1, 1'b0, 1'b0);
    drain_check(name);
  endtask

  task automatic mem_expect(input string name, input logic [15:0] addr, input logic [7:0] exp);
    tests++;
    if (mem[addr] !== exp) begin
      fails++; $display("FAIL %s mem[%h]: got %h expected %h", name, addr, mem[addr], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_wdata = '0; sel = 2'd0;
    for (int i = 0; i < 3; i++) last_rdata[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({a_ready, a_rsp_valid, a_rdata, a_cs, a_wr, a_addr, a_data} !== {1'b1, 43'd0}) begin
      fails++; $display("FAIL reset_a: got rdy %0b rsp %0b rd %h cs %0b addr %h expected 1 0 0 0 0", a_ready, a_rsp_valid, a_rdata, a_cs, a_addr);
    end
    tests++;
    if ({b_ready, b_rsp_valid, b_rdata, b_cs, b_wr, b_addr, b_data} !== {1'b1, 59'd0}) begin
      fails++; $display("FAIL reset_b: got rdy %0b rsp %0b rd %h cs %0b addr %h expected 1 0 0 0 0", b_ready, b_rsp_valid, b_rdata, b_cs, b_addr);
    end
    tests++;
    if ({c_ready, c_rsp_valid, c_rdata, c_cs, c_wr, c_addr, c_data} !== {1'b1, 35'd0}) begin
      fails++; $display("FAIL reset_c: got rdy %0b rsp %0b rd %h cs %0b addr %h expected 1 0 0 0 0", c_ready, c_rsp_valid, c_rdata, c_cs, c_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_le();
    sel = 2'd0;
    do_req("w16_beef", 1'b1, 16'h0100, 32'h0000_BEEF, '0);
    mem_expect("w16_beef", 16'h0100, 8'hEF);
    mem_expect("w16_beef", 16'h0101, 8'hBE);
  endtask

  task automatic test_roundtrip_le();
    logic [15:0] addr;
    logic [31:0] w;
    sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      addr = 16'h1000 + 16'($urandom_range(0, 16'h0FFF));
      w = {16'd0, 16'($urandom)};
      do_req("rt16_wr", 1'b1, addr, w, '0);
      do_req("rt16_rd", 1'b0, addr, '0, w);
      do_req("rt16_hold", 1'b1, addr + 16'd2, 32'h0000_5555, '0);
    end
  endtask

  task automatic test_wrap();
    sel = 2'd0;
    do_req("wrap_wr", 1'b1, 16'hFFFF, 32'h0000_A55A, '0);
    mem_expect("wrap_wr", 16'hFFFF, 8'h5A);
    mem_expect("wrap_wr", 16'h0000, 8'hA5);
    do_req("wrap_rd", 1'b0, 16'hFFFF, '0, 32'h0000_A55A);
  endtask

  task automatic test_back_to_back();
    sel = 2'd0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_address = 16'h0300; req_wdata = 32'h0000_1234;
    push_req(1'b1, 16'h0300, 32'h0000_1234, '0);
    @(posedge clk);
    for (int unsigned c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_address = 16'h0400; req_wdata = 32'h0000_ABCD;
        push_req(1'b1, 16'h0400, 32'h0000_ABCD, '0);
      end
      if (c == 5) req_valid = 1'b0;
      observe_cycle("b2b", (c == 4) || (c == 8), (c == 1) || (c == 2) || (c == 5) || (c == 6),
                    (c == 3) || (c == 7));
    end
    drain_check("b2b");
    mem_expect("b2b", 16'h0300, 8'h34);
    mem_expect("b2b", 16'h0301, 8'h12);
    mem_expect("b2b", 16'h0400, 8'hCD);
    mem_expect("b2b", 16'h0401, 8'hAB);
  endtask

  task automatic test_reset_priority();
    sel = 2'd0;
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_address = 16'h0600; req_wdata = 32'h7777;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) last_rdata[i] = '0;
    for (int c = 0; c < 4; c++) begin
      observe_cycle("rst_prio", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    drain_check("rst_prio");
  endtask

  task automatic test_read_be();
    logic [15:0] addr;
    logic [31:0] w;
    sel = 2'd1;
    do_req("be_wr", 1'b1, 16'h0200, 32'h1234_5678, '0);
    mem_expect("be_wr", 16'h0200, 8'h12);
    mem_expect("be_wr", 16'h0201, 8'h34);
    mem_expect("be_wr", 16'h0202, 8'h56);
    mem_expect("be_wr", 16'h0203, 8'h78);
    do_req("be_rd", 1'b0, 16'h0200, '0, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      addr = 16'h2000 + 16'($urandom_range(0, 16'h0FFF));
      w = $urandom;
      do_req("be_rt_wr", 1'b1, addr, w, '0);
      do_req("be_rt_rd", 1'b0, addr, '0, w);
    end
  endtask

  task automatic test_reset_abort();
    strobe_t s;
    sel = 2'd1;
    do_req("abort_pre", 1'b1, 16'h0500, 32'hEEEE_EEEE, '0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_address = 16'h0500; req_wdata = 32'h1122_3344;
    s.addr = 16'h0500; s.data = 8'h11; s.wr = 1'b1; sq.push_back(s);
    s.addr = 16'h0501; s.data = 8'h22; sq.push_back(s);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    observe_cycle("abort", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    observe_cycle("abort", 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_rdata[i] = '0;
    for (int c = 0; c < 6; c++) begin
      observe_cycle("abort_after", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    drain_check("abort");
    tests++;
    if (b_rdata !== 32'd0) begin
      fails++; $display("FAIL abort rdata: got %h expected 00000000", b_rdata);
    end
    mem_expect("abort", 16'h0500, 8'h11);
    mem_expect("abort", 16'h0501, 8'h22);
    mem_expect("abort", 16'h0502, 8'hEE);
    mem_expect("abort", 16'h0503, 8'hEE);
  endtask

  task automatic test_byte_wide();
    sel = 2'd2;
    do_req("w8_wr", 1'b1, 16'h0010, 32'h0000_005A, '0);
    mem_expect("w8_wr", 16'h0010, 8'h5A);
    do_req("w8_rd", 1'b0, 16'h0010, '0, 32'h0000_005A);
    do_req("w8_wr2", 1'b1, 16'hFFFF, 32'h0000_00C3, '0);
    mem_expect("w8_wr2", 16'hFFFF, 8'hC3);
    do_req("w8_rd2", 1'b0, 16'hFFFF, '0, 32'h0000_00C3);
  endtask

  initial begin
    test_reset();
    test_write_le();
    test_roundtrip_le();
    test_wrap();
    test_back_to_back();
    test_reset_priority();
    test_read_be();
    test_reset_abort();
    test_byte_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
